// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W SRAM block.
//   sram_state_e : controller state (zero-init sweep, one-cycle wait, running)
//   wide_t       : fixed-width carrier for lane_merge; callers size-cast in and out
//   lane_merge   : per-lane select of new over old data, used by array and bypass
package sram_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN_WAIT = 2'd1,
    RUN      = 2'd2
  } sram_state_e;

  // Upper bound on DATA_WIDTH; lane_merge works on this width so one
  // function serves every instance regardless of its parameters.
  localparam int MAX_WIDTH = 2048;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  // Bit b comes from new_word when its lane (b / gran) is enabled in mask.
  function automatic wide_t lane_merge(input wide_t old_word, input wide_t new_word,
                                       input wide_t mask, input int gran);
    wide_t res;
    res = old_word;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      res[b] = mask[b / gran] ? new_word[b] : old_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_1r1w_array.sv
// Behavioural DEPTH x DATA_WIDTH storage with one masked write port and one
// synchronous read port returning the word as it was before the same edge.
// No reset: contents are only ever set through the write port.
//   clk   : clock
//   we    : write enable;  waddr/wdata/wmask : write address, data, lane mask
//   re    : read enable;   raddr : read address;  rdata : registered read data
module sram_1r1w_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 8,
  parameter int MASK_GRAN  = 8,
  parameter int NUM_WMASKS = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NUM_WMASKS-1:0] wmask,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Masked write: disabled lanes keep their stored bits.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= DATA_WIDTH'(lane_merge(wide_t'(mem_r[waddr]), wide_t'(wdata),
                                             wide_t'(wmask), MASK_GRAN));
    end
  end

  // Read register only moves on an enabled read so it holds between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/sram_1r1w_bypass_ctrl.sv
// 1-write/1-read SRAM controller: post-reset zero sweep, write-first
// read-during-write bypass, read latency 1 or 2, read-valid tracking.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ready             : high once requests are accepted
//   csb0/addr0/wmask0/din0 : write port (select active low, per-lane mask)
//   csb1/addr1        : read port (select active low)
//   dout1/dout1_vld   : read data and its one-cycle valid pulse
//   rw_coll           : same-edge read/write to one address, aligned with dout1_vld
module sram_1r1w_bypass_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 8,
  parameter int MASK_GRAN  = 8,
  parameter int READ_LAT   = 1,
  parameter int INIT_ZERO  = 1,
  parameter int NUM_WMASKS = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  csb0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  rw_coll
);

  if (MASK_GRAN < 1 || (DATA_WIDTH % MASK_GRAN) != 0 || (READ_LAT != 1 && READ_LAT != 2)
      || DATA_WIDTH > MAX_WIDTH) begin : g_bad_params
    $error("sram_1r1w_bypass_ctrl: illegal DATA_WIDTH/MASK_GRAN/READ_LAT combination");
  end

  localparam sram_state_e RESET_STATE = (INIT_ZERO != 0) ? INIT : RUN_WAIT;

  sram_state_e           state_r, state_next_s;
  logic [ADDR_WIDTH:0]   sweep_ptr_r;   // extra MSB flags end of sweep
  logic                  sweep_we_s;
  logic                  ready_r;
  logic                  wr_user_s, rd_acc_s, coll_s;
  logic                  arr_we_s;
  logic [ADDR_WIDTH-1:0] arr_waddr_s;
  logic [DATA_WIDTH-1:0] arr_wdata_s;
  logic [NUM_WMASKS-1:0] arr_wmask_s;
  logic [DATA_WIDTH-1:0] arr_q_s;
  logic                  s1_vld_r, s1_coll_r, s1_has_r;
  logic [DATA_WIDTH-1:0] byp_data_r;
  logic [NUM_WMASKS-1:0] byp_mask_r;
  logic [DATA_WIDTH-1:0] merged_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= RESET_STATE;
    else        state_r <= state_next_s;
  end

  // Next state: the sweep ends once the pointer has passed the last word.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT:     if (sweep_ptr_r[ADDR_WIDTH]) state_next_s = RUN;
                else                         state_next_s = INIT;
      RUN_WAIT: state_next_s = RUN;
      RUN:      state_next_s = RUN;
      default:  state_next_s = RESET_STATE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    sweep_we_s = 1'b0;
    case (state_r)
      INIT:     sweep_we_s = ~sweep_ptr_r[ADDR_WIDTH];
      RUN_WAIT: sweep_we_s = 1'b0;
      RUN:      sweep_we_s = 1'b0;
      default:  sweep_we_s = 1'b0;
    endcase
  end

  // Sweep pointer, one word per cycle while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sweep_ptr_r <= (ADDR_WIDTH+1)'(0);
    else if (sweep_we_s) sweep_ptr_r <= sweep_ptr_r + (ADDR_WIDTH+1)'(1);
    else                 sweep_ptr_r <= sweep_ptr_r;
  end

  // Ready registered from next state so it rises on the edge entering RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_r <= 1'b0;
    else        ready_r <= (state_next_s == RUN);
  end

  assign ready     = ready_r;
  assign wr_user_s = ready_r & ~csb0;
  assign rd_acc_s  = ready_r & ~csb1;
  assign coll_s    = rd_acc_s & wr_user_s & (addr0 == addr1);

  // Write-port mux: the sweep owns the port until ready.
  always_comb begin
    if (sweep_we_s) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = sweep_ptr_r[ADDR_WIDTH-1:0];
      arr_wdata_s = {DATA_WIDTH{1'b0}};
      arr_wmask_s = {NUM_WMASKS{1'b1}};
    end else begin
      arr_we_s    = wr_user_s;
      arr_waddr_s = addr0;
      arr_wdata_s = din0;
      arr_wmask_s = wmask0;
    end
  end

  sram_1r1w_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MASK_GRAN  (MASK_GRAN),
    .NUM_WMASKS (NUM_WMASKS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .wmask (arr_wmask_s),
    .re    (rd_acc_s),
    .raddr (addr1),
    .rdata (arr_q_s)
  );

  // Read stage 1: capture bypass data alongside the array read. A
  // non-colliding read stores an empty mask so the merge passes the array word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r   <= 1'b0;
      s1_coll_r  <= 1'b0;
      s1_has_r   <= 1'b0;
      byp_data_r <= {DATA_WIDTH{1'b0}};
      byp_mask_r <= {NUM_WMASKS{1'b0}};
    end else begin
      s1_vld_r  <= rd_acc_s;
      s1_coll_r <= coll_s;
      if (rd_acc_s) begin
        s1_has_r   <= 1'b1;
        byp_data_r <= din0;
        byp_mask_r <= coll_s ? wmask0 : {NUM_WMASKS{1'b0}};
      end
    end
  end

  // Until the first read after reset the array register is undefined; show zero.
  assign merged_s = s1_has_r
                  ? DATA_WIDTH'(lane_merge(wide_t'(arr_q_s), wide_t'(byp_data_r),
                                           wide_t'(byp_mask_r), MASK_GRAN))
                  : {DATA_WIDTH{1'b0}};

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  vld_r, coll_r;

    // Output register: holds the captured word, so later writes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_r <= {DATA_WIDTH{1'b0}};
        vld_r  <= 1'b0;
        coll_r <= 1'b0;
      end else begin
        vld_r  <= s1_vld_r;
        coll_r <= s1_coll_r;
        if (s1_vld_r) dout_r <= merged_s;
      end
    end

    assign dout1     = dout_r;
    assign dout1_vld = vld_r;
    assign rw_coll   = coll_r;
  end else begin : g_lat1
    assign dout1     = merged_s;
    assign dout1_vld = s1_vld_r;
    assign rw_coll   = s1_coll_r;
  end

endmodule
